hrd_tile_locator: RTL
=====================

// Module: hrd_tile_locator
// PURPOSE
//  Pixel-to-piece lookup stage feeding the 16:1 colour mux select (S).
//  Holds the 4x5 Klotski board (one 4-bit piece ID per cell).
//  Maps each incoming VGA pixel coordinate to the piece ID under it and the pixel offset within its cell.
//  ID 0 means empty or off-board; the mux then outputs white.
// PARAMETERS
//  COLS       4    board columns
//  ROWS       5    board rows
//  CELL_SHIFT 6    log2 of cell edge in pixels (64 px cells)
//  ORG_X      192  board left edge, pixels
//  ORG_Y      80   board top edge, pixels
// PORTS
//  clk       in   1   pixel clock
//  rst       in   1   async reset, active-high
//  pix_x     in   10  current pixel column
//  pix_y     in   10  current pixel row
//  pix_vld   in   1   coordinate valid (active video)
//  wr_en     in   1   board cell write strobe (from game logic)
//  wr_cell   in   5   cell index = row*COLS+col, 0..19
//  wr_id     in   4   piece ID to store
//  sel       out  4   piece ID -> mux S
//  off_x     out  6   x offset inside cell (sprite ROM addr)
//  off_y     out  6   y offset inside cell
//  cell_idx  out  5   board cell index of pixel, 0 when off-board
//  out_vld   out  1   outputs valid
//  ready     out  1   board initialised, writes accepted
// BEHAVIOUR
//  Reset: all outputs 0, board cells 0, FSM -> INIT, init counter 0.
//  FSM INIT: one cell per cycle is written from the default layout, cells 0..19 (20 cycles).
//   Then RUN; ready=1 from the cycle after the last write.
//  FSM RUN: stays in RUN until rst.
//  Default layout, rows top->bottom: 2 1 1 3 / 2 1 1 3 / 4 5 5 6 / 4 7 8 6 / 9 0 0 10.
//  wr_en is ignored in INIT.
//  In RUN, a write updates the cell at the next clk edge. Out-of-range wr_cell (>19) is ignored.
//  Pipeline, latency 2 cycles from pix_* to outputs; fully pipelined, 1 pixel/cycle.
//   S1: dx=pix_x-ORG_X, dy=pix_y-ORG_Y (11-bit signed).
//    on = pix_vld & dx>=0 & dy>=0 & dx<COLS<<CELL_SHIFT & dy<ROWS<<CELL_SHIFT.
//    col=dx>>CELL_SHIFT, row=dy>>CELL_SHIFT, offsets = low CELL_SHIFT bits; register all.
//   S2: read board[row*COLS+col]. sel = on ? id : 0; cell_idx = on ? idx : 0.
//    off_x/off_y pass through (0 when !on).
//  out_vld = pix_vld delayed 2 cycles, independent of on.
//  Read/write same cell same cycle: S2 returns the old value (write-after-read).
//  During INIT, sel=0 for every pixel; out_vld still tracks pix_vld.
//  rst mid-INIT or mid-RUN: board cleared, pipeline flushed, INIT restarts from cell 0.
//  Edges: pix_x=ORG_X+255 -> col 3; ORG_X+256 -> off-board. pix_x<ORG_X -> off-board (sign of dx).
// STRUCTURE
//  Package hrd_pkg: COLS/ROWS/CELL_SHIFT/ORG_X/ORG_Y defaults, NUM_CELLS=20.
//   Also piece_id_t (4-bit), state enum {INIT,RUN}, DEFAULT_LAYOUT constant array.
//  One sub-module: hrd_board_regs
//   20x4 register file, 1 write port, 1 comb read port, async clear.
//  FSM, init counter and 2-stage pipeline stay in top.
// TESTING
//  1 Reset, release -> ready=0 for 20 cycles, ready=1 on cycle 21; board equals default layout.
//  2 RUN, pix_vld=1, (192,80) -> 2 cycles later sel=2, cell_idx=0, off=(0,0), out_vld=1.
//    (330,150) -> sel=1, cell_idx=6, off=(10,6).
//  3 (191,80), (448,80) and (192,400) -> sel=0, cell_idx=0, out_vld=1.
//    (447,399) -> sel=10, cell_idx=19, off=(63,63).
//  4 Write cell 17 id 1 in the same cycle pixel (260,350) enters S2 -> sel=0 (old value).
//    Same pixel one cycle later -> sel=1.
//  5 wr_en at cycle 5 of INIT with wr_cell=0, wr_id=15 -> ignored; cell 0 ends =2.
//    Then wr_cell=25 in RUN -> no cell changes.
//  6 Assert rst at INIT cycle 10 and during RUN with pixels in flight.
//    -> out_vld/sel drop to 0 immediately; init restarts, ready after 20 cycles.

Source files
------------

// File: rtl/hrd_pkg.sv
// rtl/hrd_pkg.sv - board geometry, piece/state types and default Klotski layout
package hrd_pkg;

    localparam int COLS       = 4;
    localparam int ROWS       = 5;
    localparam int CELL_SHIFT = 6;
    localparam int ORG_X      = 192;
    localparam int ORG_Y      = 80;
    localparam int NUM_CELLS  = COLS * ROWS;

    typedef logic [3:0] piece_id_t;
    typedef logic [4:0] cell_idx_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Rows top to bottom; ID 0 marks the two empty cells.
    localparam piece_id_t DEFAULT_LAYOUT [NUM_CELLS] = '{
        4'd2, 4'd1, 4'd1, 4'd3,
        4'd2, 4'd1, 4'd1, 4'd3,
        4'd4, 4'd5, 4'd5, 4'd6,
        4'd4, 4'd7, 4'd8, 4'd6,
        4'd9, 4'd0, 4'd0, 4'd10
    };

    function automatic cell_idx_t cell_index(input logic [2:0] row, input logic [1:0] col);
        return cell_idx_t'(int'(row) * COLS + int'(col));
    endfunction

endpackage

// File: rtl/hrd_tile_locator_if.sv
// rtl/hrd_tile_locator_if.sv - pixel, board-write and lookup-result signals of the tile locator
interface hrd_tile_locator_if;
    import hrd_pkg::*;

    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       pix_vld;
    logic       wr_en;
    cell_idx_t  wr_cell;
    piece_id_t  wr_id;
    piece_id_t  sel;
    logic [5:0] off_x;
    logic [5:0] off_y;
    cell_idx_t  cell_idx;
    logic       out_vld;
    logic       ready;

    modport master (
        output pix_x, pix_y, pix_vld, wr_en, wr_cell, wr_id,
        input  sel, off_x, off_y, cell_idx, out_vld, ready
    );

    modport slave (
        input  pix_x, pix_y, pix_vld, wr_en, wr_cell, wr_id,
        output sel, off_x, off_y, cell_idx, out_vld, ready
    );

endinterface

// File: rtl/hrd_board_regs.sv
// rtl/hrd_board_regs.sv - 20x4 board register file, one write port, one combinational read port
module hrd_board_regs
    import hrd_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      we_i,
    input  cell_idx_t waddr_i,
    input  piece_id_t wdata_i,
    input  cell_idx_t raddr_i,
    output piece_id_t rdata_o
);

    piece_id_t mem_q [NUM_CELLS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CELLS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i < cell_idx_t'(NUM_CELLS))) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // A read of the cell being written returns the stored (old) value.
    assign rdata_o = (raddr_i < cell_idx_t'(NUM_CELLS)) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/hrd_tile_locator.sv
// rtl/hrd_tile_locator.sv - maps VGA pixel coordinates to the Klotski piece ID and in-cell offset
module hrd_tile_locator
    import hrd_pkg::*;
#(
    parameter int ORG_X_P = ORG_X,
    parameter int ORG_Y_P = ORG_Y
) (
    input logic          clk,
    input logic          rst,
    hrd_tile_locator_if.slave loc_if
);

    state_e    state_q;
    cell_idx_t init_cnt_q;
    logic      ready_q;

    logic      bw_en;
    cell_idx_t bw_addr;
    piece_id_t bw_data;
    piece_id_t rd_id;
    cell_idx_t rd_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    if (init_cnt_q == cell_idx_t'(NUM_CELLS - 1)) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end else begin
                        init_cnt_q <= init_cnt_q + 5'd1;
                    end
                end
                RUN: state_q <= RUN;
                default: state_q <= INIT;
            endcase
        end
    end

    // The init sequencer owns the write port until the layout is loaded.
    always_comb begin
        bw_en   = 1'b0;
        bw_addr = loc_if.wr_cell;
        bw_data = loc_if.wr_id;
        if (state_q == INIT) begin
            bw_en   = 1'b1;
            bw_addr = init_cnt_q;
            bw_data = DEFAULT_LAYOUT[init_cnt_q];
        end else begin
            bw_en   = loc_if.wr_en;
        end
    end

    hrd_board_regs u_board (
        .clk     (clk),
        .rst     (rst),
        .we_i    (bw_en),
        .waddr_i (bw_addr),
        .wdata_i (bw_data),
        .raddr_i (rd_idx),
        .rdata_o (rd_id)
    );

    // Stage 1: board-relative coordinates, sign bit flags pixels left/above the board.
    logic [10:0] dx;
    logic [10:0] dy;
    logic        s1_on_d;
    logic        s1_on_q;
    logic        s1_vld_q;
    logic [1:0]  s1_col_q;
    logic [2:0]  s1_row_q;
    logic [5:0]  s1_offx_q;
    logic [5:0]  s1_offy_q;

    assign dx = {1'b0, loc_if.pix_x} - 11'(ORG_X_P);
    assign dy = {1'b0, loc_if.pix_y} - 11'(ORG_Y_P);

    assign s1_on_d = loc_if.pix_vld & ~dx[10] & ~dy[10]
                   & (dx < 11'(COLS << CELL_SHIFT))
                   & (dy < 11'(ROWS << CELL_SHIFT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_on_q   <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_col_q  <= '0;
            s1_row_q  <= '0;
            s1_offx_q <= '0;
            s1_offy_q <= '0;
        end else begin
            s1_on_q   <= s1_on_d;
            s1_vld_q  <= loc_if.pix_vld;
            s1_col_q  <= dx[7:6];
            s1_row_q  <= dy[8:6];
            s1_offx_q <= dx[5:0];
            s1_offy_q <= dy[5:0];
        end
    end

    // Stage 2: board lookup; the partially loaded board is masked until RUN.
    piece_id_t  sel_q;
    cell_idx_t  cell_idx_q;
    logic [5:0] off_x_q;
    logic [5:0] off_y_q;
    logic       out_vld_q;

    assign rd_idx = cell_index(s1_row_q, s1_col_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q      <= '0;
            cell_idx_q <= '0;
            off_x_q    <= '0;
            off_y_q    <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            sel_q      <= (s1_on_q && (state_q == RUN)) ? rd_id : '0;
            cell_idx_q <= s1_on_q ? rd_idx : '0;
            off_x_q    <= s1_on_q ? s1_offx_q : '0;
            off_y_q    <= s1_on_q ? s1_offy_q : '0;
            out_vld_q  <= s1_vld_q;
        end
    end

    assign loc_if.sel      = sel_q;
    assign loc_if.cell_idx = cell_idx_q;
    assign loc_if.off_x    = off_x_q;
    assign loc_if.off_y    = off_y_q;
    assign loc_if.out_vld  = out_vld_q;
    assign loc_if.ready    = ready_q;

endmodule
